fp32_to_int32_seq: RTL and testbench

Sequential converter from IEEE-754 single precision to a signed two's-complement integer. It is the denormalising counterpart of the FPU's normalise/pack path: it takes the packed sign/exponent/mantissa format produced by the add/sub, multiply and divide units and turns it back into an integer. The magnitude is aligned by one left shift per clock, so no wide barrel shifter is needed. The block sits downstream of the FPU result bus and uses a valid/ready handshake on both sides.

---
 rtl/fp32_to_int32_seq.sv | 155 +++++++++++++++
 tb/tb_fp32_to_int32_seq.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/fp32_to_int32_seq.sv
// IEEE-754 single precision to signed INT_W-bit integer, one alignment shift per clock.
// Define FP2INT_RNE_EN for round-to-nearest-even; otherwise the result truncates toward zero.
module fp32_to_int32_seq #(
  parameter int INT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_res,
  output logic             out_invalid,
  output logic             out_inexact
);

  localparam int ACC_W = INT_W + 23;
  localparam int CNT_W = $clog2(INT_W);
  localparam logic [7:0] EXP_LIM = 8'(127 + INT_W - 1);
  localparam logic [INT_W-1:0] INT_MAX = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] INT_MIN = {1'b1, {(INT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

  state_t            state_reg;
  logic [ACC_W-1:0]  acc_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              sign_reg;
  logic              sat_reg;
  logic              ready_reg;
  logic              valid_reg;
  logic [INT_W-1:0]  res_reg;
  logic              invalid_reg;
  logic              inexact_reg;

  logic [7:0]        exp_f;
  logic [22:0]       frac_f;
  logic [23:0]       mant;
  logic [ACC_W-1:0]  acc_init;
  logic [CNT_W-1:0]  cnt_init;
  logic              sat_init;
  logic              to_shift;

  assign exp_f  = in_a[30:23];
  assign frac_f = in_a[22:0];
  assign mant   = {1'b1, frac_f};

  // Every operand that needs no alignment is reduced here to a preset
  // accumulator whose guard/sticky bits already carry the lost fraction.
  always_comb begin
    acc_init = '0;
    cnt_init = '0;
    sat_init = 1'b0;
    to_shift = 1'b0;
    if (exp_f >= EXP_LIM) begin
      if (in_a[31] && (exp_f == EXP_LIM) && (frac_f == 23'd0))
        acc_init = ACC_W'(mant) << (INT_W - 1);
      else
        sat_init = 1'b1;
    end else if (exp_f == 8'd0) begin
      acc_init = ACC_W'(|frac_f);
    end else if (exp_f < 8'd126) begin
      acc_init = ACC_W'(1'b1);
    end else if (exp_f == 8'd126) begin
      acc_init = ACC_W'(mant >> 1) | ACC_W'(frac_f[0]);
    end else begin
      acc_init = ACC_W'(mant);
      cnt_init = CNT_W'(exp_f - 8'd127);
      to_shift = (exp_f != 8'd127);
    end
  end

  logic [INT_W-1:0]  int_part;
  logic              guard;
  logic              sticky;
  logic              inc;
  logic [INT_W-1:0]  mag;
  logic [INT_W-1:0]  round_res;

  assign int_part = acc_reg[ACC_W-1:23];
  assign guard    = acc_reg[22];
  assign sticky   = |acc_reg[21:0];
`ifdef FP2INT_RNE_EN
  assign inc      = guard & (sticky | int_part[0]);
`else
  assign inc      = 1'b0;
`endif
  // Carry out of the increment cannot overflow: aligned magnitudes stay below 2^(INT_W-1).
  assign mag       = int_part + INT_W'(inc);
  assign round_res = sign_reg ? -mag : mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      acc_reg     <= '0;
      cnt_reg     <= '0;
      sign_reg    <= 1'b0;
      sat_reg     <= 1'b0;
      ready_reg   <= 1'b0;
      valid_reg   <= 1'b0;
      res_reg     <= '0;
      invalid_reg <= 1'b0;
      inexact_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          ready_reg <= 1'b1;
          if (in_valid && ready_reg) begin
            ready_reg <= 1'b0;
            acc_reg   <= acc_init;
            cnt_reg   <= cnt_init;
            sign_reg  <= in_a[31];
            sat_reg   <= sat_init;
            state_reg <= to_shift ? SHIFT : ROUND;
          end
        end
        SHIFT: begin
          acc_reg <= acc_reg << 1;
          cnt_reg <= cnt_reg - 1'b1;
          if (cnt_reg == CNT_W'(1))
            state_reg <= ROUND;
        end
        ROUND: begin
          if (sat_reg) begin
            res_reg     <= sign_reg ? INT_MIN : INT_MAX;
            invalid_reg <= 1'b1;
            inexact_reg <= 1'b0;
          end else begin
            res_reg     <= round_res;
            invalid_reg <= 1'b0;
            inexact_reg <= guard | sticky;
          end
          valid_reg <= 1'b1;
          state_reg <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready    = ready_reg;
  assign out_valid   = valid_reg;
  assign out_res     = res_reg;
  assign out_invalid = invalid_reg;
  assign out_inexact = inexact_reg;

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Directed-vector bench for fp32_to_int32_seq with INT_W = 32, both rounding builds.
module tb_fp32_to_int32_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = 32'd0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_res;
  logic        out_invalid;
  logic        out_inexact;

  int checks = 0;
  int errors = 0;

  fp32_to_int32_seq #(.INT_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_invalid(out_invalid), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] res;
    logic        inv;
    logic        inex;
    int          lat;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Wait for ready, accept one operand, and measure latency as edges from the
  // accept edge through the edge that raises out_valid. Leaves the result held.
  task automatic start_and_wait(input logic [31:0] a, output int lat);
    for (int i = 0; i < 100 && !in_ready; i++) begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1;
    in_a     = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take_result();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] r15, r075, rn15;
`ifdef FP2INT_RNE_EN
    r15 = 32'd2;  r075 = 32'd1;  rn15 = 32'hFFFFFFFE;
`else
    r15 = 32'd1;  r075 = 32'd0;  rn15 = 32'hFFFFFFFF;
`endif
    vecs[0]  = '{32'h40490FDB, 32'd3,        1'b0, 1'b1, 3};
    vecs[1]  = '{32'hC2F6E666, 32'hFFFFFF85, 1'b0, 1'b1, 8};
    vecs[2]  = '{32'h3FC00000, r15,          1'b0, 1'b1, 2};
    vecs[3]  = '{32'h40200000, 32'd2,        1'b0, 1'b1, 3};
    vecs[4]  = '{32'h3F000000, 32'd0,        1'b0, 1'b1, 2};
    vecs[5]  = '{32'h4F000000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    vecs[6]  = '{32'hCF000000, 32'h80000000, 1'b0, 1'b0, 2};
    vecs[7]  = '{32'h7FC00000, 32'h7FFFFFFF, 1'b1, 1'b0, 2};
    vecs[8]  = '{32'h80000000, 32'd0,        1'b0, 1'b0, 2};
    vecs[9]  = '{32'h3F400000, r075,         1'b0, 1'b1, 2};
    vecs[10] = '{32'h00000001, 32'd0,        1'b0, 1'b1, 2};
    vecs[11] = '{32'hFF800000, 32'h80000000, 1'b1, 1'b0, 2};
    vecs[12] = '{32'hBFC00000, rn15,         1'b0, 1'b1, 2};
    vecs[13] = '{32'h4EFFFFFF, 32'h7FFFFF80, 1'b0, 1'b0, 32};
    vecs[14] = '{32'hBE800000, 32'd0,        1'b0, 1'b1, 2};
    vecs[15] = '{32'h3F800000, 32'd1,        1'b0, 1'b0, 2};
    vecs[16] = '{32'hCF000001, 32'h80000000, 1'b1, 1'b0, 2};

    // Reset state
    #2;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_res", out_res, 32'd0);
    chk("reset_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 17; i++) begin
      start_and_wait(vecs[i].a, lat);
      $display("conv a=0x%08h res=0x%08h inv=%0b inex=%0b lat=%0d",
               vecs[i].a, out_res, out_invalid, out_inexact, lat);
      chk($sformatf("v%0d_res", i), out_res, vecs[i].res);
      chk($sformatf("v%0d_invalid", i), {31'd0, out_invalid}, {31'd0, vecs[i].inv});
      chk($sformatf("v%0d_inexact", i), {31'd0, out_inexact}, {31'd0, vecs[i].inex});
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      take_result();
    end

    // Backpressure: result held for five cycles with out_ready low
    start_and_wait(32'h41200000, lat);
    $display("conv a=0x41200000 res=0x%08h lat=%0d (held)", out_res, lat);
    chk("bp_latency", lat, 5);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp_valid_%0d", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_res_%0d", k), out_res, 32'd10);
      chk($sformatf("bp_in_ready_%0d", k), {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    take_result();
    chk("bp_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("bp_ready_back", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a 32-cycle conversion
    in_valid = 1'b1;
    in_a     = 32'h4E800000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("mid_rst_out_res", out_res, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_ready_after", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_no_result", {31'd0, out_valid}, 32'd0);
    start_and_wait(32'h3F800000, lat);
    $display("conv a=0x3F800000 res=0x%08h lat=%0d (after reset)", out_res, lat);
    chk("post_rst_res", out_res, 32'd1);
    chk("post_rst_latency", lat, 2);
    chk("post_rst_flags", {30'd0, out_invalid, out_inexact}, 32'd0);
    take_result();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
